// File: rtl/fnd_scan_capture.sv
// rtl/fnd_scan_capture.sv - captures a multiplexed 4-digit FND scan and rebuilds the decimal value
module fnd_scan_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_fndSelect,
  input  logic [7:0]  i_fndFont,
  output logic [13:0] o_value,
  output logic        o_valid,
  output logic        o_error,
  output logic        o_timeout,
  output logic [3:0]  o_digitMask
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [1:0]       rst_pipe;
  logic             rst;
  logic [3:0]       sel_sync  [SYNC_STAGES];
  logic [7:0]       font_sync [SYNC_STAGES];
  logic [3:0]       cur_sel, prev_sel;
  logic [7:0]       cur_font, prev_font;
  logic [SCW-1:0]   stab_cnt;
  logic [TW-1:0]    tcnt;
  logic             same, event_hit, sel_ok, accept, complete, timeout_hit;
  logic [1:0]       sel_idx;
  logic [4:0]       dec;
  logic [1:0]       state;
  logic [3:0]       mask, mask_n, err, err_n;
  logic [3:0][3:0]  d, d_n, d_snap;
  logic             err_any;
  logic [13:0]      p_hi, p_lo;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) rst_pipe <= 2'b11;
    else         rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  // Synchronisers idle at the blank pattern so no spurious pair appears at reset release.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sel_sync[i]  <= 4'hF;
        font_sync[i] <= 8'hFF;
      end
    end else begin
      sel_sync[0]  <= i_fndSelect;
      font_sync[0] <= i_fndFont;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sel_sync[i]  <= sel_sync[i-1];
        font_sync[i] <= font_sync[i-1];
      end
    end
  end

  assign cur_sel  = sel_sync[SYNC_STAGES-1];
  assign cur_font = font_sync[SYNC_STAGES-1];
  assign same      = ({cur_sel, cur_font} == {prev_sel, prev_font});
  assign event_hit = same && (stab_cnt == SCW'(STABLE_CYCLES - 2));

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      prev_sel  <= 4'hF;
      prev_font <= 8'hFF;
      stab_cnt  <= '0;
    end else begin
      prev_sel  <= cur_sel;
      prev_font <= cur_font;
      if (!same)
        stab_cnt <= '0;
      else if (stab_cnt != SCW'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + SCW'(1);
    end
  end

  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   decode = 5'd0;
      7'h79:   decode = 5'd1;
      7'h24:   decode = 5'd2;
      7'h30:   decode = 5'd3;
      7'h19:   decode = 5'd4;
      7'h12:   decode = 5'd5;
      7'h02:   decode = 5'd6;
      7'h78:   decode = 5'd7;
      7'h00:   decode = 5'd8;
      7'h10:   decode = 5'd9;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (cur_sel)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  assign accept = event_hit && sel_ok;
  assign dec    = decode(cur_font[6:0]);

  always_comb begin
    mask_n = mask;
    d_n    = d;
    err_n  = err;
    if (accept) begin
      mask_n[sel_idx] = 1'b1;
      d_n[sel_idx]    = dec[3:0];
      err_n[sel_idx]  = dec[4];
    end
  end

  assign complete    = (state == S_COLLECT) && (mask_n == 4'hF);
  assign timeout_hit = !accept && (mask != 4'h0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state     <= S_COLLECT;
      mask      <= '0;
      d         <= '0;
      err       <= '0;
      d_snap    <= '0;
      err_any   <= 1'b0;
      p_hi      <= '0;
      p_lo      <= '0;
      tcnt      <= '0;
      o_value   <= '0;
      o_valid   <= 1'b0;
      o_error   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      d         <= d_n;
      err       <= err_n;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;

      if (complete) begin
        mask    <= '0;
        d_snap  <= d_n;
        err_any <= |err_n;
      end else if (timeout_hit) begin
        mask      <= '0;
        o_timeout <= 1'b1;
      end else begin
        mask <= mask_n;
      end

      if (accept || (mask == 4'h0) || timeout_hit)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);

      // Events keep landing in mask/d while the snapshot is being summed.
      case (state)
        S_COLLECT: if (complete) state <= S_CALC;
        S_CALC: begin
          p_hi  <= 14'(d_snap[3]) * 14'd1000 + 14'(d_snap[2]) * 14'd100;
          p_lo  <= 14'(d_snap[1]) * 14'd10 + 14'(d_snap[0]);
          state <= S_EMIT;
        end
        S_EMIT: begin
          o_value <= p_hi + p_lo;
          o_error <= err_any;
          o_valid <= 1'b1;
          state   <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

  assign o_digitMask = mask;

endmodule
